// File: rtl/mips150_mem_access_pkg.sv
// Shared encodings, state enum and store-lane helpers for the MIPS150 MEM-stage access block.
package mips150_mem_pkg;

  typedef enum logic [2:0] {
    MASK_LB  = 3'b000,
    MASK_LH  = 3'b001,
    MASK_LW  = 3'b010,
    MASK_LBU = 3'b011,
    MASK_LHU = 3'b100
  } mask_e;

  typedef enum logic [1:0] {
    MW_NONE = 2'b00,
    MW_SB   = 2'b01,
    MW_SH   = 2'b10,
    MW_SW   = 2'b11
  } mw_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    RESP  = 2'b11
  } state_e;

  // Operation context held from accept until the response is produced.
  typedef struct packed {
    logic       is_store;
    mask_e      mask;
    logic [1:0] offset;
  } op_t;

  // Big-endian byte enables: offset 0 is lane [31:24].
  function automatic logic [3:0] store_we(input mw_e mw, input logic [1:0] offset);
    logic [3:0] we;
    we = 4'b0000;
    case (mw)
      MW_SB:   we = 4'b1000 >> offset;
      MW_SH:   we = offset[1] ? 4'b0011 : 4'b1100;
      MW_SW:   we = 4'b1111;
      default: we = 4'b0000;
    endcase
    return we;
  endfunction

  function automatic logic [31:0] store_data(input mw_e mw, input logic [31:0] wdata);
    logic [31:0] d;
    d = '0;
    case (mw)
      MW_SB:   d = {4{wdata[7:0]}};
      MW_SH:   d = {2{wdata[15:0]}};
      MW_SW:   d = wdata;
      default: d = '0;
    endcase
    return d;
  endfunction

  // Store type wins over load when both are requested.
  function automatic logic is_misaligned(input logic is_store, input mw_e mw,
                                         input mask_e mask, input logic [1:0] offset);
    logic bad;
    bad = 1'b0;
    if (is_store) begin
      bad = ((mw == MW_SH) && offset[0]) || ((mw == MW_SW) && (offset != 2'b00));
    end else begin
      bad = (((mask == MASK_LH) || (mask == MASK_LHU)) && offset[0]) ||
            ((mask == MASK_LW) && (offset != 2'b00));
    end
    return bad;
  endfunction

endpackage

// File: rtl/mips150_mem_access_if.sv
// Pipeline request/response and data-memory bus bundle; addr_err exists only with MIPS150_MISALIGN_TRAP_EN.
interface mips150_mem_access_if #(
  parameter int unsigned ADDR_W = 12
);
  logic              req_valid;
  logic              req_ready;
  logic              is_load;
  logic [2:0]        mask;
  logic [1:0]        mem_write;
  logic [31:0]       addr;
  logic [31:0]       wdata;
  logic              resp_valid;
  logic [31:0]       resp_data;
  logic              bus_err;
  logic              dmem_en;
  logic [3:0]        dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [31:0]       dmem_wdata;
  logic [31:0]       dmem_rdata;
  logic              dmem_ack;
`ifdef MIPS150_MISALIGN_TRAP_EN
  logic              addr_err;
`endif

  modport slave (
    input  req_valid, is_load, mask, mem_write, addr, wdata, dmem_rdata, dmem_ack,
`ifdef MIPS150_MISALIGN_TRAP_EN
    output addr_err,
`endif
    output req_ready, resp_valid, resp_data, bus_err,
    output dmem_en, dmem_we, dmem_addr, dmem_wdata
  );

  modport master (
    output req_valid, is_load, mask, mem_write, addr, wdata, dmem_rdata, dmem_ack,
`ifdef MIPS150_MISALIGN_TRAP_EN
    input  addr_err,
`endif
    input  req_ready, resp_valid, resp_data, bus_err,
    input  dmem_en, dmem_we, dmem_addr, dmem_wdata
  );

endinterface

// File: rtl/mips150_load_align.sv
// Extracts the addressed byte/halfword/word from big-endian read data and sign/zero-extends it.
module mips150_load_align
  import mips150_mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  mask_e       mask,
  input  logic [1:0]  offset,
  output logic [31:0] result_c
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[31:24];
    case (offset)
      2'd0:    byte_sel = rdata[31:24];
      2'd1:    byte_sel = rdata[23:16];
      2'd2:    byte_sel = rdata[15:8];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = offset[1] ? rdata[15:0] : rdata[31:16];

    result_c = '0;
    case (mask)
      MASK_LB:  result_c = {{24{byte_sel[7]}}, byte_sel};
      MASK_LBU: result_c = {24'd0, byte_sel};
      MASK_LH:  result_c = {{16{half_sel[15]}}, half_sel};
      MASK_LHU: result_c = {16'd0, half_sel};
      MASK_LW:  result_c = rdata;
      default:  result_c = '0;
    endcase
  end

endmodule

// File: rtl/mips150_mem_access.sv
// MEM-stage load/store engine: one request -> one byte-enabled dmem access -> one response.
// Optional misalignment trap via MIPS150_MISALIGN_TRAP_EN.
module mips150_mem_access
  import mips150_mem_pkg::*;
#(
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  mips150_mem_access_if.slave  bus
);

  localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

  state_e      state;
  op_t         op;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic        is_store_c;
  logic        accept_c;
  logic        timeout_c;
  logic [31:0] align_c;
  mw_e         mw_c;
  mask_e       mask_in_c;
  logic        unused_addr;

  assign bus.req_ready = (state == IDLE);
  assign mw_c          = mw_e'(bus.mem_write);
  assign mask_in_c     = mask_e'(bus.mask);
  assign is_store_c    = (mw_c != MW_NONE);
  assign accept_c      = bus.req_valid && (state == IDLE) && (bus.is_load || is_store_c);
  assign cnt_inc       = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);
  assign timeout_c     = (TIMEOUT != 0) && (cnt_inc == CNT_W'(TIMEOUT));
  assign unused_addr   = &{1'b0, bus.addr[31:ADDR_W+2]};

  mips150_load_align u_align (
    .rdata    (bus.dmem_rdata),
    .mask     (op.mask),
    .offset   (op.offset),
    .result_c (align_c)
  );

  // Single-process FSM with all bus outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      op             <= '0;
      cnt            <= '0;
      bus.resp_valid <= 1'b0;
      bus.resp_data  <= '0;
      bus.bus_err    <= 1'b0;
      bus.dmem_en    <= 1'b0;
      bus.dmem_we    <= '0;
      bus.dmem_addr  <= '0;
      bus.dmem_wdata <= '0;
`ifdef MIPS150_MISALIGN_TRAP_EN
      bus.addr_err   <= 1'b0;
`endif
    end else begin
      bus.resp_valid <= 1'b0;
      bus.bus_err    <= 1'b0;
`ifdef MIPS150_MISALIGN_TRAP_EN
      bus.addr_err   <= 1'b0;
`endif
      case (state)
        IDLE: begin
          bus.resp_data <= '0;
          if (accept_c) begin
            op  <= '{is_store: is_store_c, mask: mask_in_c, offset: bus.addr[1:0]};
            cnt <= '0;
`ifdef MIPS150_MISALIGN_TRAP_EN
            if (is_misaligned(is_store_c, mw_c, mask_in_c, bus.addr[1:0])) begin
              state          <= RESP;
              bus.resp_valid <= 1'b1;
              bus.addr_err   <= 1'b1;
            end else begin
`else
            begin
`endif
              state          <= ISSUE;
              bus.dmem_en    <= 1'b1;
              bus.dmem_we    <= store_we(mw_c, bus.addr[1:0]);
              bus.dmem_addr  <= bus.addr[ADDR_W+1:2];
              bus.dmem_wdata <= store_data(mw_c, bus.wdata);
            end
          end
        end
        ISSUE: begin
          bus.dmem_en <= 1'b0;
          bus.dmem_we <= '0;
          state       <= WAIT;
        end
        WAIT: begin
          cnt <= cnt_inc;
          // Ack beats a timeout landing in the same cycle.
          if (bus.dmem_ack) begin
            state          <= RESP;
            bus.resp_valid <= 1'b1;
            bus.resp_data  <= op.is_store ? 32'd0 : align_c;
          end else if (timeout_c) begin
            state          <= RESP;
            bus.resp_valid <= 1'b1;
            bus.bus_err    <= 1'b1;
            bus.resp_data  <= '0;
          end
        end
        RESP: begin
          bus.resp_data <= '0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
